// File: rtl/reg_file_scoreboard.sv
// Architectural register file with asynchronous read ports, one synchronous write port,
// write-first bypass and a per-register pending-write scoreboard for RAW stall detection.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         reg_write_enable_i,
  input  logic [ADDR_W-1:0]            a3_i,
  input  logic [DATA_W-1:0]            reg_write_data_i,
  input  logic [NUM_READ*ADDR_W-1:0]   ra_i,
  output logic [NUM_READ*DATA_W-1:0]   rd_o,
  input  logic                         issue_valid_i,
  input  logic [ADDR_W-1:0]            issue_rd_i,
  output logic [NUM_READ-1:0]          busy_o,
  output logic                         hazard_o
);

  // Every encodable address gets a slot; slots outside DEPTH (and x0 when hard-wired)
  // are masked off, so they are never written and always read as zero.
  localparam int SLOTS = 1 << ADDR_W;

  function automatic logic [SLOTS-1:0] build_mask();
    logic [SLOTS-1:0] m;
    for (int i = 0; i < SLOTS; i++) begin
      m[i] = (i < DEPTH) && !((ZERO_REG != 0) && (i == 0));
    end
    return m;
  endfunction

  localparam logic [SLOTS-1:0] LIVE = build_mask();

  logic [DATA_W-1:0] regs [SLOTS];
  logic [SLOTS-1:0]  busy;
  logic [SLOTS-1:0]  busy_next;
  logic              write_hit;
  logic              issue_hit;

  assign write_hit = reg_write_enable_i && LIVE[a3_i];
  assign issue_hit = issue_valid_i && LIVE[issue_rd_i];

  // NOTE: busy_next takes the current vector first, so every path assigns it and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (write_hit) busy_next[a3_i] = 1'b0;
    // Applied after the clear: a new producer supersedes the one writing back.
    if (issue_hit) busy_next[issue_rd_i] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy <= '0;
    else       busy <= busy_next;
  end

  // NOTE: the whole array is reset because software relies on registers reading zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SLOTS; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[a3_i] <= reg_write_data_i;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic              visible;
    logic              bypass;

    assign addr    = ra_i[k*ADDR_W +: ADDR_W];
    assign visible = !rst_i && LIVE[addr];
    assign bypass  = reg_write_enable_i && (a3_i == addr);

    assign rd_o[k*DATA_W +: DATA_W] = !visible ? '0 :
                                      bypass   ? reg_write_data_i : regs[addr];
    // A value arriving on the bypass this cycle satisfies the dependency.
    assign busy_o[k] = visible && busy[addr] && !bypass;
  end

  assign hazard_o = |busy_o;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench: stimulus queues expected read/busy responses per cycle, a negedge
// monitor pops and compares them against two configurations of reg_file_scoreboard.
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Configuration A: defaults (32 x 32, two ports, hard-wired x0)
  logic        a_we;
  logic [4:0]  a_a3;
  logic [31:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic        a_iv;
  logic [4:0]  a_ird;
  logic [1:0]  a_busy;
  logic        a_hz;

  reg_file_scoreboard dut_a (
    .clk_i              (clk),
    .rst_i              (rst),
    .reg_write_enable_i (a_we),
    .a3_i               (a_a3),
    .reg_write_data_i   (a_wd),
    .ra_i               (a_ra),
    .rd_o               (a_rd),
    .issue_valid_i      (a_iv),
    .issue_rd_i         (a_ird),
    .busy_o             (a_busy),
    .hazard_o           (a_hz)
  );

  // Configuration B: 64 x 16, three ports, x0 is an ordinary register, 5-bit addresses
  logic         b_we;
  logic [4:0]   b_a3;
  logic [63:0]  b_wd;
  logic [14:0]  b_ra;
  logic [191:0] b_rd;
  logic         b_iv;
  logic [4:0]   b_ird;
  logic [2:0]   b_busy;
  logic         b_hz;

  reg_file_scoreboard #(
    .DATA_W   (64),
    .DEPTH    (16),
    .NUM_READ (3),
    .ZERO_REG (0),
    .ADDR_W   (5)
  ) dut_b (
    .clk_i              (clk),
    .rst_i              (rst),
    .reg_write_enable_i (b_we),
    .a3_i               (b_a3),
    .reg_write_data_i   (b_wd),
    .ra_i               (b_ra),
    .rd_o               (b_rd),
    .issue_valid_i      (b_iv),
    .issue_rd_i         (b_ird),
    .busy_o             (b_busy),
    .hazard_o           (b_hz)
  );

  typedef struct {
    int           cyc;
    string        name;
    bit           on_b;
    logic [191:0] rd;
    logic [2:0]   busy;
    logic         hazard;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every expectation queued for the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, " cycle"}, 192'(cyc), 192'(mon_e.cyc));
      if (mon_e.on_b) begin
        check({mon_e.name, " rd"}, b_rd, mon_e.rd);
        check({mon_e.name, " busy"}, 192'(b_busy), 192'(mon_e.busy));
        check({mon_e.name, " hazard"}, 192'(b_hz), 192'(mon_e.hazard));
      end else begin
        check({mon_e.name, " rd"}, {128'b0, a_rd}, mon_e.rd);
        check({mon_e.name, " busy"}, 192'(a_busy), 192'(mon_e.busy));
        check({mon_e.name, " hazard"}, 192'(a_hz), 192'(mon_e.hazard));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    a_we = we; a_a3 = a3; a_wd = wd; a_iv = iv; a_ird = ird; a_ra = {ra1, ra0};
  endtask

  task automatic set_b(input logic we, input logic [4:0] a3, input logic [63:0] wd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    b_we = we; b_a3 = a3; b_wd = wd; b_iv = iv; b_ird = ird; b_ra = {ra2, ra1, ra0};
  endtask

  task automatic exp_a(input string name, input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic [1:0] busy, input logic hz);
    exp_t e;
    e.cyc = cyc; e.name = name; e.on_b = 1'b0;
    e.rd = {128'b0, rd1, rd0}; e.busy = {1'b0, busy}; e.hazard = hz;
    exp_q.push_back(e);
  endtask

  task automatic exp_b(input string name, input logic [63:0] rd0, input logic [63:0] rd1,
                       input logic [63:0] rd2, input logic [2:0] busy, input logic hz);
    exp_t e;
    e.cyc = cyc; e.name = name; e.on_b = 1'b1;
    e.rd = {rd2, rd1, rd0}; e.busy = busy; e.hazard = hz;
    exp_q.push_back(e);
  endtask

  localparam logic [63:0] K0  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] K3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K15 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] K8  = 64'h8888_0000_0000_8888;

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held: bypass disabled, write in flight is lost
    step(); set_a(1, 5, 32'h1111, 1, 5, 5, 5);         exp_a("rst_bypass_off", 0, 0, 2'b00, 0);
    step(); rst = 1'b0;
            set_a(0, 0, 0, 0, 0, 5, 5);                exp_a("rst_write_lost", 0, 0, 2'b00, 0);

    // Write then read
    step(); set_a(1, 5, 32'hDEADBEEF, 0, 0, 0, 5);     exp_a("x5_bypass", 0, 32'hDEADBEEF, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 3, 5);                exp_a("x5_storage", 0, 32'hDEADBEEF, 2'b00, 0);

    // Hard-wired zero register
    step(); set_a(1, 0, 32'h12345678, 1, 0, 0, 0);     exp_a("x0_write_cycle", 0, 0, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 0, 0);                exp_a("x0_after", 0, 0, 2'b00, 0);

    // Scoreboard: issue, stall, writeback
    step(); set_a(0, 0, 0, 1, 7, 7, 5);                exp_a("x7_issue", 0, 32'hDEADBEEF, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 7, 5);                exp_a("x7_busy", 0, 32'hDEADBEEF, 2'b01, 1);
    step(); set_a(1, 7, 32'h55, 0, 0, 7, 5);           exp_a("x7_wb_bypass", 32'h55, 32'hDEADBEEF, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 7, 5);                exp_a("x7_cleared", 32'h55, 32'hDEADBEEF, 2'b00, 0);

    // Busy on port 1, duplicate issue, single writeback clears
    step(); set_a(0, 0, 0, 1, 12, 5, 12);              exp_a("x12_issue", 32'hDEADBEEF, 0, 2'b00, 0);
    step(); set_a(0, 0, 0, 1, 12, 5, 12);              exp_a("x12_busy_p1", 32'hDEADBEEF, 0, 2'b10, 1);
    step(); set_a(0, 0, 0, 0, 0, 5, 12);               exp_a("x12_dup_issue", 32'hDEADBEEF, 0, 2'b10, 1);
    step(); set_a(1, 12, 32'hC0FFEE, 0, 0, 5, 12);     exp_a("x12_wb", 32'hDEADBEEF, 32'hC0FFEE, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 5, 12);               exp_a("x12_cleared", 32'hDEADBEEF, 32'hC0FFEE, 2'b00, 0);

    // Simultaneous set and clear on x9: set wins
    step(); set_a(1, 9, 32'hA5, 1, 9, 9, 0);           exp_a("x9_set_clr", 32'hA5, 0, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 9, 0);                exp_a("x9_still_busy", 32'hA5, 0, 2'b01, 1);
    // Clear x9 while setting x20 on the same edge
    step(); set_a(1, 9, 32'h5A, 1, 20, 9, 20);         exp_a("x9_clr_x20_set", 32'h5A, 0, 2'b00, 0);
    step(); set_a(0, 0, 0, 0, 0, 9, 20);               exp_a("x20_busy", 32'h5A, 0, 2'b10, 1);
    step(); set_a(1, 20, 32'h20, 0, 0, 9, 20);         exp_a("x20_wb", 32'h5A, 32'h20, 2'b00, 0);
    step(); set_a(0, 0, 0, 1, 5, 9, 20);               exp_a("x20_cleared", 32'h5A, 32'h20, 2'b00, 0);

    // Asynchronous reset pulse between edges clears data and the pending x5 issue
    step(); set_a(0, 0, 0, 0, 0, 5, 9);
            rst = 1'b1; #2; rst = 1'b0;                exp_a("rst_pulse", 0, 0, 2'b00, 0);
    for (int i = 0; i < 16; i++) begin
      step(); set_a(0, 0, 0, 0, 0, 5'(2*i), 5'(2*i+1)); exp_a($sformatf("rst_sweep_%0d", i), 0, 0, 2'b00, 0);
    end

    // Configuration B
    step(); set_b(1, 0, K0, 0, 0, 0, 16, 17);          exp_b("b_x0_bypass", K0, 0, 0, 3'b000, 0);
    step(); set_b(0, 0, 0, 0, 0, 0, 16, 17);           exp_b("b_x0_storage", K0, 0, 0, 3'b000, 0);
    step(); set_b(1, 17, 64'hBAD, 1, 17, 17, 1, 16);   exp_b("b_a17_write", 0, 0, 0, 3'b000, 0);
    step(); set_b(0, 0, 0, 0, 0, 17, 1, 16);           exp_b("b_a17_ignored", 0, 0, 0, 3'b000, 0);
    step(); set_b(1, 3, K3, 1, 15, 0, 3, 15);          exp_b("b_x3_write", K0, K3, 0, 3'b000, 0);
    step(); set_b(1, 15, K15, 1, 8, 0, 3, 15);         exp_b("b_x15_write", K0, K3, K15, 3'b000, 0);
    step(); set_b(0, 0, 0, 0, 0, 15, 8, 0);            exp_b("b_x8_busy", K15, 0, K0, 3'b010, 1);
    step(); set_b(1, 8, K8, 0, 0, 3, 15, 8);           exp_b("b_x8_wb", K3, K15, K8, 3'b000, 0);
    step(); set_b(0, 0, 0, 0, 0, 8, 0, 3);             exp_b("b_three_ports", K8, K0, K3, 3'b000, 0);

    step(); step();
    check("queue_drained", 192'(exp_q.size()), 192'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised successor to the core's single-cycle register file: DEPTH×DATA_W architectural registers with NUM_READ asynchronous read ports, one synchronous write port, an optional hard-wired zero register, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (read and issue) and writeback in the pipelined core. Decode uses the per-port busy flags and the hazard flag to stall on RAW dependencies.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; ADDR_W = $clog2(DEPTH)
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked busy
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- reg_write_enable_i  in  1  writeback strobe
- a3_i  in  ADDR_W  writeback register address
- reg_write_data_i  in  DATA_W  writeback data
- ra_i  in  NUM_READ*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_o  out  NUM_READ*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- issue_valid_i  in  1  decode issues an instruction that will write issue_rd_i
- issue_rd_i  in  ADDR_W  destination register of the issuing instruction
- busy_o  out  NUM_READ  port k reads a register with a pending write not satisfied this cycle
- hazard_o  out  1  OR of busy_o

## Operation
- Storage: DEPTH×DATA_W array plus a DEPTH-bit busy vector.
- Reset, whenever rst_i is high: all registers = 0 and all busy bits = 0 immediately, without waiting for a clock edge. While reset is high, rd_o = 0, busy_o = 0 and hazard_o = 0, and bypass is disabled.
- Write: on a rising edge with reg_write_enable_i = 1, the register at a3_i takes reg_write_data_i.
  - The write is ignored if a3_i ≥ DEPTH.
  - The write is ignored if ZERO_REG = 1 and a3_i = 0.
- Read, combinational per port:
  - Returns 0 if the address ≥ DEPTH, or if ZERO_REG = 1 and the address = 0.
  - Otherwise returns reg_write_data_i if reg_write_enable_i = 1 and a3_i equals the address (write-first bypass).
  - Otherwise returns the stored value.
- Scoreboard:
  - issue_valid_i = 1 sets busy[issue_rd_i] at the edge.
  - reg_write_enable_i = 1 clears busy[a3_i] at the edge.
  - Addresses ≥ DEPTH, and address 0 when ZERO_REG = 1, are ignored by both set and clear.
- Simultaneous set and clear on the same register: set wins and the busy bit stays 1, because the new producer supersedes the one writing back. Set and clear on different registers both take effect.
- busy_o[k] = busy[ra_k] AND NOT (reg_write_enable_i AND a3_i == ra_k). A bypassed read is not a hazard.
- busy_o[k] is 0 for address 0 when ZERO_REG = 1, and for out-of-range addresses.
- There is no flush input. Decode flushes by asserting rst_i, or by writing back every squashed destination.

## Timing
- Read latency: 0 cycles, purely combinational from ra_i, a3_i, reg_write_enable_i and reg_write_data_i.
- Write and scoreboard latency: 1 edge. The value is visible from storage on the cycle after the write edge, and from bypass during the write cycle.
- busy_o and hazard_o are combinational from the busy vector and the current writeback inputs.
- Reset asserted mid-write: the write is lost and the register reads 0.
- First edge after reset deasserts: normal write and issue processing.
- Duplicate issue to an already-busy register: the bit stays 1 (no counting). A single writeback clears it.

## Test plan
- Reset check: pulse rst_i asynchronously between edges, then read all 32 registers on ports 0 and 1 -> all rd_o = 0, hazard_o = 0 immediately, before any edge.
- Write then read: write 0xDEADBEEF to x5, and read x5 on port 1 in the same cycle -> rd_o port 1 = 0xDEADBEEF via bypass with busy_o = 0. Read x5 on the next cycle -> 0xDEADBEEF from storage.
- Zero register: with ZERO_REG = 1, write 0x12345678 to x0 and issue x0 -> reads of x0 return 0, busy_o = 0 on all cycles.
- Scoreboard sequence:
  - Issue x7, then read x7 on port 0 the next cycle -> busy_o[0] = 1, hazard_o = 1.
  - Write x7 = 0x55 -> busy_o[0] = 0 that cycle, rd_o = 0x55.
  - Next cycle -> busy_o[0] = 0.
- Simultaneous set and clear: issue x9 and write x9 = 0xA5 on the same edge -> x9 reads 0xA5, busy[9] = 1 afterwards. A later write to x9 clears it.
- Parametric run: DATA_W = 64, DEPTH = 16, NUM_READ = 3, ZERO_REG = 0.
  - Write 0xFFFF_0000_FFFF_0000 to x0 -> reads back that value.
  - Write to address 17 -> ignored; reading address 17 returns 0.
  - All three ports read different registers independently.
